// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/writeback bus of the scoreboarded register file
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] rd_addr1, rd_addr2, res_addr, wr_addr;
    logic [DATA_WIDTH-1:0] rd_data1, rd_data2, wr_data;
    logic                  rd_busy1, rd_busy2, res_en, res_ack, wr_en, flush;
    logic [ADDR_WIDTH:0]   busy_cnt;
    modport master (
        output rd_addr1, rd_addr2, res_en, res_addr, wr_en, wr_addr, wr_data, flush,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, res_ack, busy_cnt
    );
    modport slave (
        input  rd_addr1, rd_addr2, res_en, res_addr, wr_en, wr_addr, wr_data, flush,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, res_ack, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: 2R/1W register file with per-register busy scoreboard; REGFILE_BYPASS_EN enables write-to-read bypass
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic clk,
    input logic rst_n,
    reg_file_sb_if.slave bus
);
    localparam int NREG = 1 << ADDR_WIDTH;
    localparam int CW = ADDR_WIDTH + 1;
    logic [DATA_WIDTH-1:0] regs [NREG];
    logic [NREG-1:0]       busy;
    logic [CW-1:0]         cnt;
    logic                  wr_hit, wr_clr, res_set, byp1, byp2;
    assign wr_hit  = bus.wr_en && bus.wr_addr != '0;
    assign wr_clr  = wr_hit && busy[bus.wr_addr];
    assign bus.res_ack = bus.res_en && !bus.flush && (bus.res_addr == '0 || !busy[bus.res_addr]);
    assign res_set = bus.res_ack && bus.res_addr != '0;
`ifdef REGFILE_BYPASS_EN
    assign byp1 = wr_hit && bus.wr_addr == bus.rd_addr1;
    assign byp2 = wr_hit && bus.wr_addr == bus.rd_addr2;
`else
    assign byp1 = 1'b0;
    assign byp2 = 1'b0;
`endif
    assign bus.rd_data1 = byp1 ? bus.wr_data : bus.rd_addr1 == '0 ? '0 : regs[bus.rd_addr1];
    assign bus.rd_data2 = byp2 ? bus.wr_data : bus.rd_addr2 == '0 ? '0 : regs[bus.rd_addr2];
    assign bus.rd_busy1 = !byp1 && busy[bus.rd_addr1];
    assign bus.rd_busy2 = !byp2 && busy[bus.rd_addr2];
    assign bus.busy_cnt = cnt;
    // a reservation on the written register is ordered after the clear, so it wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr_hit) regs[bus.wr_addr] <= bus.wr_data;
            if (bus.flush) busy <= '0;
            else begin
                if (wr_hit) busy[bus.wr_addr] <= 1'b0;
                if (res_set) busy[bus.res_addr] <= 1'b1;
            end
            cnt <= bus.flush ? '0 : cnt + CW'(res_set) - CW'(wr_clr);
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb
module tb_reg_file_sb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;
    reg_file_sb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();
    reg_file_sb #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic idle;
        bus.res_en = 1'b0;
        bus.wr_en  = 1'b0;
        bus.flush  = 1'b0;
    endtask
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
    endtask
    task automatic res(input logic [4:0] a);
        bus.res_en = 1'b1;
        bus.res_addr = a;
    endtask
    initial begin
        idle();
        bus.rd_addr1 = '0; bus.rd_addr2 = '0;
        bus.res_addr = '0; bus.wr_addr = '0; bus.wr_data = '0;
        repeat (2) tick();
        check("rst_cnt", bus.busy_cnt, 0);
        rst_n = 1'b1;
        tick();
        // write, then read back; writes to x0 are dropped
        wr(5, 32'hDEADBEEF); bus.rd_addr1 = 5;
        tick(); idle();
        check("rd_x5", bus.rd_data1, 32'hDEADBEEF);
        check("rd_x5_busy", bus.rd_busy1, 0);
        wr(0, 32'h1234); bus.rd_addr1 = 0;
        tick(); idle();
        check("rd_x0", bus.rd_data1, 0);
        // reservation, WAW reject, writeback clear
        res(7); bus.rd_addr1 = 7; #1;
        check("res7_ack", bus.res_ack, 1);
        tick();
        check("res7_busy", bus.rd_busy1, 1);
        check("res7_cnt", bus.busy_cnt, 1);
        check("res7_waw_ack", bus.res_ack, 0);
        tick(); idle();
        check("res7_waw_cnt", bus.busy_cnt, 1);
        wr(7, 32'h55);
        tick(); idle();
        check("wr7_busy", bus.rd_busy1, 0);
        check("wr7_cnt", bus.busy_cnt, 0);
        check("wr7_data", bus.rd_data1, 32'h55);
        // x0 reservation acks without tracking
        res(0); #1;
        check("res0_ack", bus.res_ack, 1);
        tick(); idle();
        check("res0_cnt", bus.busy_cnt, 0);
        // same-cycle write and reserve on a busy register
        res(3); bus.rd_addr1 = 3;
        tick(); idle();
        wr(3, 32'hA5); res(3); #1;
        check("wr3res3_ack", bus.res_ack, 0);
        tick(); idle();
        check("wr3res3_data", bus.rd_data1, 32'hA5);
        check("wr3res3_busy", bus.rd_busy1, 0);
        check("wr3res3_cnt", bus.busy_cnt, 0);
        res(3); #1;
        check("retry3_ack", bus.res_ack, 1);
        tick(); idle();
        check("retry3_busy", bus.rd_busy1, 1);
        check("retry3_cnt", bus.busy_cnt, 1);
        wr(3, 32'hA6);
        tick(); idle();
        check("clr3_cnt", bus.busy_cnt, 0);
        // same-cycle write and reserve on an idle register: reservation wins
        wr(10, 32'h10); res(10); bus.rd_addr1 = 10; #1;
        check("wr10res10_ack", bus.res_ack, 1);
        tick(); idle();
        check("wr10res10_busy", bus.rd_busy1, 1);
        check("wr10res10_data", bus.rd_data1, 32'h10);
        check("wr10res10_cnt", bus.busy_cnt, 1);
        // write to x10 while reserving x11: count unchanged
        wr(10, 32'h11); res(11);
        tick(); idle();
        check("swap_cnt", bus.busy_cnt, 1);
        check("swap_busy10", bus.rd_busy1, 0);
        wr(11, 32'h0);
        tick(); idle();
        check("clr11_cnt", bus.busy_cnt, 0);
        // flush kills reservations and a same-cycle reserve, write still lands
        res(1); tick(); res(2); tick(); res(4); tick(); idle();
        check("three_cnt", bus.busy_cnt, 3);
        bus.flush = 1'b1; res(9); wr(2, 32'h22); bus.rd_addr1 = 1; bus.rd_addr2 = 9; #1;
        check("flush_ack", bus.res_ack, 0);
        tick(); idle();
        check("flush_cnt", bus.busy_cnt, 0);
        check("flush_busy1", bus.rd_busy1, 0);
        check("flush_busy9", bus.rd_busy2, 0);
        bus.rd_addr1 = 2; #1;
        check("flush_wr2", bus.rd_data1, 32'h22);
        // bypass on a reserved register
        res(6); tick(); idle();
        wr(6, 32'h77); bus.rd_addr2 = 6; #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_data", bus.rd_data2, 32'h77);
        check("byp_busy", bus.rd_busy2, 0);
`else
        check("byp_data", bus.rd_data2, 0);
        check("byp_busy", bus.rd_busy2, 1);
`endif
        tick(); idle();
        check("byp_after_data", bus.rd_data2, 32'h77);
        check("byp_after_busy", bus.rd_busy2, 0);
        check("byp_after_cnt", bus.busy_cnt, 0);
        // asynchronous reset mid-cycle with a pending reservation
        res(8); tick(); idle();
        bus.rd_addr1 = 5; bus.rd_addr2 = 8; #1;
        check("pre_rst_busy8", bus.rd_busy2, 1);
        #1 rst_n = 1'b0; #1;
        check("arst_data5", bus.rd_data1, 0);
        check("arst_busy8", bus.rd_busy2, 0);
        check("arst_cnt", bus.busy_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_cnt", bus.busy_cnt, 0);
        check("post_rst_data5", bus.rd_data1, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
